// File: rtl/battle_engine_param.sv
// battle_engine_param: parametrised turn-based battle resolver with a level-scaled HP table,
// per-fighter weapon ammo and an LFSR-driven hit roll behind a valid/ready attack handshake.
module battle_engine_param #(
  parameter int HP_W = 8,
  parameter int AMMO_W = 2,
  parameter int LEVELS = 5,
  parameter int BASE_HP = 100,
  parameter int HP_STEP = 10,
  parameter int BOSS_HP = 190,
  parameter int DMG_STEP = 10,
  parameter int BAT_AMMO = 3,
  parameter int SWORD_AMMO = 2,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic battle_start_i,
  input  logic [2:0] level_i,
  input  logic attack_valid_i,
  input  logic attack_side_i,
  input  logic [1:0] attack_choice_i,
  output logic attack_ready_o,
  output logic result_valid_o,
  output logic hit_o,
  output logic ammo_empty_o,
  output logic [2:0] roll_o,
  output logic [HP_W-1:0] player_hp_o,
  output logic [HP_W-1:0] enemy_hp_o,
  output logic [AMMO_W-1:0] player_bat_o,
  output logic [AMMO_W-1:0] player_sword_o,
  output logic [AMMO_W-1:0] enemy_bat_o,
  output logic [AMMO_W-1:0] enemy_sword_o,
  output logic player_win_o,
  output logic enemy_win_o
);
  typedef enum logic [1:0] {IDLE, FIGHT, DONE} state_t;
  localparam logic [7:0] SEED_NZ = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [HP_W-1:0] BASE = HP_W'(BASE_HP);
  localparam logic [HP_W-1:0] BOSS = HP_W'(BOSS_HP);
  localparam logic [AMMO_W-1:0] BAT = AMMO_W'(BAT_AMMO);
  localparam logic [AMMO_W-1:0] SWORD = AMMO_W'(SWORD_AMMO);
  localparam logic [AMMO_W-1:0] ONE = AMMO_W'(1);
  state_t state_q, state_d;
  logic [7:0] lfsr_q;
  logic [2:0] roll_q, roll_d;
  logic rv_q, rv_d, hit_q, hit_d, ae_q, ae_d, pwin_q, pwin_d, ewin_q, ewin_d;
  logic [HP_W-1:0] php_q, php_d, ehp_q, ehp_d, def_hp, dmg, def_left, lvl_hp;
  logic [AMMO_W-1:0] pbat_q, pbat_d, psw_q, psw_d, ebat_q, ebat_d, esw_q, esw_d, own_ammo;
  logic boss, accept, weapon, empty, strike;
  assign boss = int'(level_i) >= LEVELS - 1;
  assign lvl_hp = HP_W'(BASE_HP + int'(level_i) * HP_STEP);
  assign attack_ready_o = state_q == FIGHT;
  // a battle_start in the same cycle wins over the attack, so the attack is simply dropped
  assign accept = attack_valid_i & attack_ready_o & ~battle_start_i;
  assign weapon = attack_choice_i[1];
  assign own_ammo = attack_choice_i[0] ? (attack_side_i ? esw_q : psw_q)
                                       : (attack_side_i ? ebat_q : pbat_q);
  assign empty = weapon && own_ammo == '0;
  assign strike = lfsr_q[2:0] > {1'b0, attack_choice_i};
  assign dmg = HP_W'((int'(attack_choice_i) + 1) * DMG_STEP);
  assign def_hp = attack_side_i ? php_q : ehp_q;
  assign def_left = (def_hp <= dmg) ? '0 : def_hp - dmg;
  always_comb begin
    state_d = state_q;
    php_d = php_q;
    ehp_d = ehp_q;
    pbat_d = pbat_q;
    psw_d = psw_q;
    ebat_d = ebat_q;
    esw_d = esw_q;
    roll_d = roll_q;
    rv_d = 1'b0;
    hit_d = 1'b0;
    ae_d = 1'b0;
    pwin_d = pwin_q;
    ewin_d = ewin_q;
    if (battle_start_i) begin
      state_d = FIGHT;
      php_d = boss ? BOSS : BASE;
      ehp_d = boss ? BOSS : lvl_hp;
      pbat_d = BAT;
      psw_d = SWORD;
      ebat_d = BAT;
      esw_d = SWORD;
      pwin_d = 1'b0;
      ewin_d = 1'b0;
    end else if (accept) begin
      rv_d = 1'b1;
      ae_d = empty;
      if (!empty) begin
        roll_d = lfsr_q[2:0];
        hit_d = strike;
        pbat_d = (weapon && !attack_choice_i[0] && !attack_side_i) ? pbat_q - ONE : pbat_q;
        psw_d = (weapon && attack_choice_i[0] && !attack_side_i) ? psw_q - ONE : psw_q;
        ebat_d = (weapon && !attack_choice_i[0] && attack_side_i) ? ebat_q - ONE : ebat_q;
        esw_d = (weapon && attack_choice_i[0] && attack_side_i) ? esw_q - ONE : esw_q;
        if (strike) begin
          php_d = attack_side_i ? def_left : php_q;
          ehp_d = attack_side_i ? ehp_q : def_left;
          if (def_left == '0) begin
            state_d = DONE;
            pwin_d = ~attack_side_i;
            ewin_d = attack_side_i;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= SEED_NZ;
      php_q <= BASE;
      ehp_q <= BASE;
      pbat_q <= BAT;
      psw_q <= SWORD;
      ebat_q <= BAT;
      esw_q <= SWORD;
      roll_q <= '0;
      rv_q <= 1'b0;
      hit_q <= 1'b0;
      ae_q <= 1'b0;
      pwin_q <= 1'b0;
      ewin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      php_q <= php_d;
      ehp_q <= ehp_d;
      pbat_q <= pbat_d;
      psw_q <= psw_d;
      ebat_q <= ebat_d;
      esw_q <= esw_d;
      roll_q <= roll_d;
      rv_q <= rv_d;
      hit_q <= hit_d;
      ae_q <= ae_d;
      pwin_q <= pwin_d;
      ewin_q <= ewin_d;
    end
  end
  assign result_valid_o = rv_q;
  assign hit_o = hit_q;
  assign ammo_empty_o = ae_q;
  assign roll_o = roll_q;
  assign player_hp_o = php_q;
  assign enemy_hp_o = ehp_q;
  assign player_bat_o = pbat_q;
  assign player_sword_o = psw_q;
  assign enemy_bat_o = ebat_q;
  assign enemy_sword_o = esw_q;
  assign player_win_o = pwin_q;
  assign enemy_win_o = ewin_q;
endmodule

// File: tb/tb_battle_engine_param.sv
// tb_battle_engine_param: table vectors, directed battle scenarios and random stimulus
// checked every cycle against a behavioural battle model.
module tb_battle_engine_param;
  logic clk, rst, battle_start_i, attack_valid_i, attack_side_i;
  logic [2:0] level_i;
  logic [1:0] attack_choice_i;
  logic attack_ready_o, result_valid_o, hit_o, ammo_empty_o, player_win_o, enemy_win_o;
  logic [2:0] roll_o;
  logic [7:0] player_hp_o, enemy_hp_o;
  logic [1:0] player_bat_o, player_sword_o, enemy_bat_o, enemy_sword_o;
  battle_engine_param dut (
    .clk(clk), .rst(rst), .battle_start_i(battle_start_i), .level_i(level_i),
    .attack_valid_i(attack_valid_i), .attack_side_i(attack_side_i),
    .attack_choice_i(attack_choice_i), .attack_ready_o(attack_ready_o),
    .result_valid_o(result_valid_o), .hit_o(hit_o), .ammo_empty_o(ammo_empty_o),
    .roll_o(roll_o), .player_hp_o(player_hp_o), .enemy_hp_o(enemy_hp_o),
    .player_bat_o(player_bat_o), .player_sword_o(player_sword_o),
    .enemy_bat_o(enemy_bat_o), .enemy_sword_o(enemy_sword_o),
    .player_win_o(player_win_o), .enemy_win_o(enemy_win_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_pass = 0, n_total = 0;
  // model: hp[0]=player hp[1]=enemy; ammo[side][0=bat,1=sword]; state 0 idle 1 fight 2 done
  int m_hp[2];
  int m_ammo[2][2];
  int m_state, m_lfsr, m_roll;
  bit m_rv, m_hit, m_ae, m_pw, m_ew;
  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  task automatic model_step(bit rs, bit bs, int lvl, bit av, bit sd, int ch);
    int dmg, d, r;
    if (rs) begin
      m_state = 0; m_hp[0] = 100; m_hp[1] = 100;
      m_ammo[0][0] = 3; m_ammo[0][1] = 2; m_ammo[1][0] = 3; m_ammo[1][1] = 2;
      m_lfsr = 'hA5; m_roll = 0; m_rv = 0; m_hit = 0; m_ae = 0; m_pw = 0; m_ew = 0;
      return;
    end
    m_rv = 0; m_hit = 0; m_ae = 0;
    if (bs) begin
      m_state = 1;
      m_hp[0] = (lvl >= 4) ? 190 : 100;
      m_hp[1] = (lvl >= 4) ? 190 : (100 + lvl * 10) % 256;
      m_ammo[0][0] = 3; m_ammo[0][1] = 2; m_ammo[1][0] = 3; m_ammo[1][1] = 2;
      m_pw = 0; m_ew = 0;
    end else if (av && m_state == 1) begin
      m_rv = 1;
      if (ch >= 2 && m_ammo[sd][ch-2] == 0) m_ae = 1;
      else begin
        if (ch >= 2) m_ammo[sd][ch-2]--;
        r = m_lfsr % 8;
        m_roll = r;
        if (r > ch) begin
          m_hit = 1;
          dmg = ((ch + 1) * 10) % 256;
          d = 1 - sd;
          m_hp[d] = (m_hp[d] <= dmg) ? 0 : m_hp[d] - dmg;
          if (m_hp[d] == 0) begin
            m_state = 2;
            if (sd == 0) m_pw = 1; else m_ew = 1;
          end
        end
      end
    end
    // x^8+x^6+x^5+x^4+1 Fibonacci shift, new bit enters at the bottom
    m_lfsr = ((m_lfsr * 2) % 256) + (((m_lfsr >> 7) + (m_lfsr >> 5) + (m_lfsr >> 4) + (m_lfsr >> 3)) % 2);
  endtask
  task automatic compare_all();
    chk("attack_ready", attack_ready_o, m_state == 1);
    chk("result_valid", result_valid_o, m_rv);
    chk("hit", hit_o, m_hit);
    chk("ammo_empty", ammo_empty_o, m_ae);
    chk("roll", roll_o, m_roll);
    chk("player_hp", player_hp_o, m_hp[0]);
    chk("enemy_hp", enemy_hp_o, m_hp[1]);
    chk("player_bat", player_bat_o, m_ammo[0][0]);
    chk("player_sword", player_sword_o, m_ammo[0][1]);
    chk("enemy_bat", enemy_bat_o, m_ammo[1][0]);
    chk("enemy_sword", enemy_sword_o, m_ammo[1][1]);
    chk("player_win", player_win_o, m_pw);
    chk("enemy_win", enemy_win_o, m_ew);
  endtask
  task automatic cycle(bit rs, bit bs, int lvl, bit av, bit sd, int ch);
    rst = rs; battle_start_i = bs; level_i = 3'(lvl);
    attack_valid_i = av; attack_side_i = sd; attack_choice_i = 2'(ch);
    @(posedge clk);
    model_step(rs, bs, lvl, av, sd, ch);
    #1;
    compare_all();
  endtask
  task automatic wait_roll(int lo, int hi);
    int n = 0;
    while (!((m_lfsr % 8) >= lo && (m_lfsr % 8) <= hi) && n < 300) begin
      cycle(0, 0, 0, 0, 0, 0);
      n++;
    end
    chk("roll_wait_bound", n < 300, 1);
  endtask
  typedef struct {
    bit rs, bs; int lvl; bit av, sd; int ch;
    bit e_ready, e_rv; int e_php, e_ehp;
  } vec_t;
  vec_t tbl[9];
  int pre;
  initial begin
    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 100, 100};
    tbl[1] = '{0, 0, 0, 1, 0, 3, 0, 0, 100, 100};
    tbl[2] = '{0, 1, 2, 0, 0, 0, 1, 0, 100, 120};
    tbl[3] = '{0, 1, 0, 0, 0, 0, 1, 0, 100, 100};
    tbl[4] = '{0, 1, 3, 1, 1, 3, 1, 0, 100, 130};
    tbl[5] = '{0, 1, 4, 0, 0, 0, 1, 0, 190, 190};
    tbl[6] = '{0, 1, 7, 0, 0, 0, 1, 0, 190, 190};
    tbl[7] = '{1, 0, 0, 1, 0, 0, 0, 0, 100, 100};
    tbl[8] = '{0, 1, 1, 1, 0, 0, 1, 0, 100, 110};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rs, tbl[i].bs, tbl[i].lvl, tbl[i].av, tbl[i].sd, tbl[i].ch);
      chk("tbl_ready", attack_ready_o, tbl[i].e_ready);
      chk("tbl_result_valid", result_valid_o, tbl[i].e_rv);
      chk("tbl_player_hp", player_hp_o, tbl[i].e_php);
      chk("tbl_enemy_hp", enemy_hp_o, tbl[i].e_ehp);
    end
    // level 2 load
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 2, 0, 0, 0);
    chk("p1_player_hp", player_hp_o, 100);
    chk("p1_enemy_hp", enemy_hp_o, 120);
    chk("p1_player_bat", player_bat_o, 3);
    chk("p1_player_sword", player_sword_o, 2);
    cycle(0, 0, 0, 0, 0, 0);
    chk("p1_ready", attack_ready_o, 1);
    // sword on roll 5 hits, kick on roll 1 misses
    wait_roll(5, 5);
    pre = enemy_hp_o;
    cycle(0, 0, 0, 1, 0, 3);
    chk("p2_sword_hit", hit_o, 1);
    chk("p2_sword_roll", roll_o, 5);
    chk("p2_sword_enemy_hp", enemy_hp_o, pre - 40);
    chk("p2_player_sword", player_sword_o, 1);
    wait_roll(1, 1);
    pre = enemy_hp_o;
    cycle(0, 0, 0, 1, 0, 1);
    chk("p2_kick_hit", hit_o, 0);
    chk("p2_kick_valid", result_valid_o, 1);
    chk("p2_kick_enemy_hp", enemy_hp_o, pre);
    // enemy bat exhaustion
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1, 2);
      chk("p3_enemy_bat", enemy_bat_o, 2 - i);
    end
    pre = player_hp_o;
    cycle(0, 0, 0, 1, 1, 2);
    chk("p3_ammo_empty", ammo_empty_o, 1);
    chk("p3_empty_hit", hit_o, 0);
    chk("p3_empty_bat", enemy_bat_o, 0);
    chk("p3_empty_player_hp", player_hp_o, pre);
    // boss fight down to 10 then killing punch
    cycle(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      wait_roll(4, 7);
      cycle(0, 0, 0, 1, 0, 3);
      chk("p4_sword_enemy_hp", enemy_hp_o, 150 - 40 * i);
    end
    for (int i = 0; i < 3; i++) begin
      wait_roll(3, 7);
      cycle(0, 0, 0, 1, 0, 2);
      chk("p4_bat_enemy_hp", enemy_hp_o, 80 - 30 * i);
    end
    wait_roll(1, 7);
    cycle(0, 0, 0, 1, 0, 0);
    chk("p4_enemy_hp_10", enemy_hp_o, 10);
    wait_roll(1, 7);
    cycle(0, 0, 0, 1, 0, 0);
    chk("p4_enemy_hp_0", enemy_hp_o, 0);
    chk("p4_player_win", player_win_o, 1);
    chk("p4_enemy_win", enemy_win_o, 0);
    chk("p4_ready_low", attack_ready_o, 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("p4_done_no_result", result_valid_o, 0);
    chk("p4_win_holds", player_win_o, 1);
    // restart from DONE with a colliding attack
    cycle(0, 1, 2, 1, 0, 3);
    chk("p5_no_result", result_valid_o, 0);
    chk("p5_win_clear", player_win_o, 0);
    chk("p5_ready", attack_ready_o, 1);
    chk("p5_enemy_hp", enemy_hp_o, 120);
    chk("p5_player_sword", player_sword_o, 2);
    // reset mid-fight, then the first roll after reload comes from the seed
    cycle(0, 0, 0, 1, 0, 1);
    cycle(1, 0, 0, 1, 0, 3);
    chk("p6_ready", attack_ready_o, 0);
    chk("p6_result", result_valid_o, 0);
    chk("p6_roll", roll_o, 0);
    chk("p6_enemy_hp", enemy_hp_o, 100);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    chk("p6_seed_roll", roll_o, 2);
    chk("p6_seed_enemy_hp", enemy_hp_o, 90);
    // random traffic
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/battle_engine_param.md
# battle_engine_param

Parametrised turn-based battle resolver for the fight screen. It replaces the fixed 8-bit engine and adds the following:
- configurable HP, damage and ammo widths and values;
- a level-scaled HP table with a boss level;
- an LFSR-driven hit roll instead of a free-running counter;
- a valid/ready attack handshake with a per-attack result pulse;
- an explicit battle FSM.

It sits between the collision/turn controller (upstream) and the HUD/score logic (downstream).

## Interface
Parameters:
- HP_W, 8: width of HP registers.
- AMMO_W, 2: width of ammo counters.
- LEVELS, 5: number of levels. The last level is the boss level.
- BASE_HP, 100: player HP at start on non-boss levels; also the level-0 enemy HP.
- HP_STEP, 10: added to enemy HP per level index on non-boss levels.
- BOSS_HP, 190: both fighters' HP on the boss level.
- DMG_STEP, 10: damage unit. Choice c deals (c+1)*DMG_STEP.
- BAT_AMMO, 3: bat uses (choice 2) per fighter per battle.
- SWORD_AMMO, 2: sword uses (choice 3) per fighter per battle.
- SEED, 8'hA5: LFSR reset value. Zero is replaced by 8'h01.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- battle_start, in, 1: load HP/ammo for `level` and enter FIGHT.
- level, in, 3: level index. Values ≥ LEVELS-1 select the boss level.
- attack_valid, in, 1: attack request.
- attack_side, in, 1: attacker. 0 = player, 1 = enemy.
- attack_choice, in, 2: 0 punch, 1 kick, 2 bat, 3 sword.
- attack_ready, out, 1: high only in FIGHT.
- result_valid, out, 1: one-cycle pulse per accepted attack.
- hit, out, 1: damage was applied. Valid with result_valid.
- ammo_empty, out, 1: the attack was refused for lack of ammo. Valid with result_valid.
- roll, out, 3: roll used by the last accepted attack.
- player_hp, out, HP_W: current player HP.
- enemy_hp, out, HP_W: current enemy HP.
- player_bat, out, AMMO_W: player bat ammo remaining.
- player_sword, out, AMMO_W: player sword ammo remaining.
- enemy_bat, out, AMMO_W: enemy bat ammo remaining.
- enemy_sword, out, AMMO_W: enemy sword ammo remaining.
- player_win, out, 1: level, high in DONE when enemy HP is 0.
- enemy_win, out, 1: level, high in DONE when player HP is 0.

## Operation
States:
- IDLE → FIGHT on battle_start.
- FIGHT → DONE when an accepted attack drives the defender's HP to 0.
- DONE → FIGHT on battle_start.
- Any state → IDLE on rst.

Reset values:
- FSM = IDLE.
- HPs = BASE_HP.
- Ammo = BAT_AMMO / SWORD_AMMO.
- LFSR = SEED.
- roll = 0.
- result_valid, hit, ammo_empty, player_win and enemy_win are all 0.

battle_start (in any non-reset state) performs the load:
- Level L < LEVELS-1: player_hp = BASE_HP, enemy_hp = BASE_HP + L*HP_STEP.
- Boss level: both HPs = BOSS_HP.
- Ammo is reloaded.
- Win flags clear.
- Values are truncated to HP_W.

LFSR:
- 8-bit Fibonacci, taps 8,6,5,4.
- Advances every clock except in reset.
- roll = lfsr[2:0] sampled at the accept edge.

Accept condition: attack_valid & attack_ready.
- For bat/sword, check the attacker's own counter first.
  - Counter 0: no damage, no roll effect, ammo_empty=1, hit=0.
  - Counter nonzero: decrement by 1, whether or not the attack hits.
- Hit when roll > attack_choice.
- Defender HP saturates: if HP ≤ damage, HP becomes 0; otherwise HP − damage.
- Damage is computed in HP_W bits.

Entering DONE sets player_win or enemy_win. Both flags hold until battle_start or rst.

Ignored input:
- attack_valid outside FIGHT is ignored: no pulse, no ammo change.
- level is sampled only on battle_start.

## Timing
Attack:
- Accept at edge N.
- HP, ammo, roll, hit, ammo_empty and result_valid are all visible after edge N.
- Latency is 1 cycle.

Handshake:
- attack_ready is combinational from state.
- Back-to-back accepts are allowed, one per cycle.
- The FIGHT→DONE transition occurs on the same edge as the killing hit. attack_ready is low from the next cycle.

Priorities:
- rst > battle_start > attack. An attack presented with battle_start is dropped, with no result_valid.
- rst mid-battle returns to IDLE with reset values on the next edge.

Pulses and holds:
- result_valid, hit and ammo_empty deassert on the next cycle unless another accept occurs.
- roll holds its value between accepts.

## Test plan
1. rst, then battle_start with level=2 → player_hp=100, enemy_hp=120, player_bat=3, player_sword=2; attack_ready=1 on the next cycle.
2. With a model-predicted roll=5, player sword (choice 3) → hit=1, enemy_hp −40, player_sword 2→1. With a predicted roll=1, player kick → hit=0, HP unchanged, result_valid=1.
3. Three enemy bat accepts, then a fourth → the fourth gives ammo_empty=1, hit=0, enemy_bat stays 0, player_hp unchanged by that attack.
4. level=4 (boss), enemy_hp forced to 10 by repeated hits, then a player punch with roll ≥ 1 → enemy_hp=0, player_win=1 after the same edge, attack_ready=0 the next cycle, further attack_valid produces no result_valid.
5. battle_start asserted together with attack_valid in DONE → HPs reload, no result_valid, win flags clear, state FIGHT.
6. rst asserted mid-FIGHT while attack_valid=1 → all outputs at reset values on the next edge, LFSR=SEED, state IDLE.
